// File: rtl/dot_operand_loader_pkg.sv
// Shared types and width helpers for the dotProduct operand loader.
//   ld_state_e    : loader FSM state encoding
//   clogb2        : ceiling log2, same rounding as the dotProduct width derivation
//   res_width     : dot-product result width for given element widths and DIM
//   idx_width     : element index width (at least 1 bit)
//   cnt_width     : latency counter width able to hold DP_LATENCY (at least 1 bit)
package dot_operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Ceiling log2; clogb2(1) == 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned res_width(input int unsigned a_w,
                                              input int unsigned b_w,
                                              input int unsigned dim);
        return a_w + b_w + clogb2(dim);
    endfunction

    function automatic int unsigned idx_width(input int unsigned dim);
        return (clogb2(dim) == 0) ? 1 : clogb2(dim);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned latency);
        return (clogb2(latency + 1) == 0) ? 1 : clogb2(latency + 1);
    endfunction

endpackage

// File: rtl/dot_operand_loader_wait.sv
// Loadable down-counter that times out the dotProduct pipeline latency.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val into the counter (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   Expired    : counter currently reads zero
module dot_operand_loader_wait #(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 Expired
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: load wins, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Expired = (cnt_q == '0);

endmodule

// File: rtl/dot_operand_loader.sv
// Packs DIM A/B element beats into wide operand vectors for dotProduct, waits
// out the engine latency, captures DotProduct and presents it on a
// valid/ready output.
//   Clock, Reset_n     : clock, async active-low reset
//   InValid/InReady    : input beat handshake (InA, InB one element each)
//   A, B               : packed operands, element k at [k*W +: W]
//   DotProduct         : result returned by the dotProduct engine
//   OutValid/OutReady  : output handshake for Result
//   Busy               : loader is not in its LOAD state
module dot_operand_loader
    import dot_operand_loader_pkg::*;
#(
    parameter int unsigned  DIM          = 10,
    parameter int unsigned  A_DATA_WIDTH = 16,
    parameter int unsigned  B_DATA_WIDTH = 16,
    parameter int unsigned  DP_LATENCY   = 2,
    localparam int unsigned RES_WIDTH    = res_width(A_DATA_WIDTH, B_DATA_WIDTH, DIM)
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [A_DATA_WIDTH-1:0]     InA,
    input  logic [B_DATA_WIDTH-1:0]     InB,
    output logic [A_DATA_WIDTH*DIM-1:0] A,
    output logic [B_DATA_WIDTH*DIM-1:0] B,
    input  logic [RES_WIDTH-1:0]        DotProduct,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [RES_WIDTH-1:0]        Result,
    output logic                        Busy
);

    localparam int unsigned IDX_W = idx_width(DIM);
    localparam int unsigned CNT_W = cnt_width(DP_LATENCY);
    localparam int unsigned A_VW  = A_DATA_WIDTH * DIM;
    localparam int unsigned B_VW  = B_DATA_WIDTH * DIM;

    ld_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [A_VW-1:0]      a_q, a_d;
    logic [B_VW-1:0]      b_q, b_d;
    logic [RES_WIDTH-1:0] result_q, result_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_expired;

    dot_operand_loader_wait #(
        .CNT_WIDTH (CNT_W)
    ) u_wait (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .load     (cnt_load),
        .load_val (CNT_W'(DP_LATENCY)),
        .dec      (cnt_dec),
        .Expired  (cnt_expired)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // in_ready_q gates the first cycle after reset release.
                if (InValid && in_ready_q) begin
                    for (int unsigned k = 0; k < DIM; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            a_d[k*A_DATA_WIDTH +: A_DATA_WIDTH] = InA;
                            b_d[k*B_DATA_WIDTH +: B_DATA_WIDTH] = InB;
                        end
                    end
                    if (idx_q == IDX_W'(DIM - 1)) begin
                        idx_d    = '0;
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_expired) begin
                    result_d    = DotProduct;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_valid_q && OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Registered state decodes; equal to the current-state decode once out of reset.
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_LOAD);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign InReady  = in_ready_q;
    assign A        = a_q;
    assign B        = b_q;
    assign Result   = result_q;
    assign OutValid = out_valid_q;
    assign Busy     = busy_q;

endmodule
